// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and types for the branch resolve unit.
package branch_resolve_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Squash counter width; holds FLUSH_DEPTH up to 7.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [0:0] {
        RESOLVE = 1'b0,
        SQUASH  = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_decide.sv
// Combinational taken / illegal / target fix-up decision for one instruction.
module branch_decide
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic            br_eq_i,
    input  logic            br_lt_i,
    input  logic            br_ltu_i,
    input  logic [XLEN-1:0] target_i,
    output logic            is_branch_o,
    output logic            taken_o,
    output logic            illegal_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] target_o
);

    // Decode opcode/funct3 into taken and illegal, clear bit 0 for JALR.
    always_comb begin
        is_branch_o = 1'b0;
        taken_o     = 1'b0;
        illegal_o   = 1'b0;
        target_o    = target_i;
        case (opcode_i)
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3_i)
                    F3_BEQ:  taken_o = br_eq_i;
                    F3_BNE:  taken_o = !br_eq_i;
                    F3_BLT:  taken_o = br_lt_i;
                    F3_BGE:  taken_o = !br_lt_i;
                    F3_BLTU: taken_o = br_ltu_i;
                    F3_BGEU: taken_o = !br_ltu_i;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_JAL: begin
                taken_o = 1'b1;
            end
            OPC_JALR: begin
                taken_o  = 1'b1;
                target_o = {target_i[XLEN-1:1], 1'b0};
            end
            default: begin
                taken_o = 1'b0;
            end
        endcase
    end

    // A taken target must be word aligned to redirect.
    assign misalign_o = taken_o && (target_o[1:0] != 2'b00);

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered PC redirect plus wrong-path squash window.
// Optional macro BRANCH_STATS_EN adds stat_branches / stat_taken counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic            br_ltu,
    input  logic [XLEN-1:0] target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            squash,
    output logic            illegal_br,
    output logic            misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken
`endif
);

    br_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_q, illegal_d;
    logic            misalign_q, misalign_d;

    logic            is_branch_c;
    logic            taken_c;
    logic            illegal_c;
    logic            misalign_c;
    logic [XLEN-1:0] target_c;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;
`endif

    branch_decide #(
        .XLEN (XLEN)
    ) u_decide (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .br_eq_i     (br_eq),
        .br_lt_i     (br_lt),
        .br_ltu_i    (br_ltu),
        .target_i    (target),
        .is_branch_o (is_branch_c),
        .taken_o     (taken_c),
        .illegal_o   (illegal_c),
        .misalign_o  (misalign_c),
        .target_o    (target_c)
    );

    // Next-state, squash counter and pulse generation.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        illegal_d        = 1'b0;
        misalign_d       = 1'b0;
`ifdef BRANCH_STATS_EN
        stat_branches_d  = stat_branches_q;
        stat_taken_d     = stat_taken_q;
`endif
        if (flush_in) begin
            state_d = RESOLVE;
            cnt_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                RESOLVE: begin
                    illegal_d = illegal_c;
                    if (taken_c && !misalign_c) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target_c;
                        state_d          = SQUASH;
                        cnt_d            = CNT_W'(FLUSH_DEPTH);
                    end else if (taken_c) begin
                        misalign_d = 1'b1;
                    end
`ifdef BRANCH_STATS_EN
                    if (is_branch_c) begin
                        stat_branches_d = stat_branches_q + 32'd1;
                    end
                    if (taken_c && !misalign_c) begin
                        stat_taken_d = stat_taken_q + 32'd1;
                    end
`endif
                end
                SQUASH: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESOLVE;
                    end
                end
                default: begin
                    state_d = RESOLVE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= RESOLVE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            illegal_q        <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_q        <= illegal_d;
            misalign_q       <= misalign_d;
        end
    end

`ifdef BRANCH_STATS_EN
    // Statistics counters; cleared by reset only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`else
    logic unused_is_branch;
    assign unused_is_branch = is_branch_c;
`endif

    assign in_ready       = 1'b1;
    assign squash         = (state_q == SQUASH) && in_valid;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign illegal_br     = illegal_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (FLUSH_DEPTH=2, XLEN=32).
module tb_branch_resolve_unit;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;
    logic        br_ltu = 1'b0;
    logic [31:0] target = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        squash;
    logic        illegal_br;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        ill;
        logic        mis;
        logic        sq_exp;
        logic        sq_obs;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_pc = 32'd0;

    branch_resolve_unit #(
        .FLUSH_DEPTH (2),
        .XLEN        (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_in       (flush_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .funct3         (funct3),
        .br_eq          (br_eq),
        .br_lt          (br_lt),
        .br_ltu         (br_ltu),
        .target         (target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .squash         (squash),
        .illegal_br     (illegal_br),
        .misalign       (misalign)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_taken     (stat_taken)
`endif
    );

    always #5 clk = ~clk;

    // Pop one expectation per clock and compare registered outputs.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks += 5;
            if (redirect_valid !== mon_e.rv) begin
                errors++;
                $display("FAIL redirect_valid t=%0t got %b want %b", $time, redirect_valid, mon_e.rv);
            end
            if (redirect_pc !== mon_e.pc) begin
                errors++;
                $display("FAIL redirect_pc t=%0t got %h want %h", $time, redirect_pc, mon_e.pc);
            end
            if (illegal_br !== mon_e.ill) begin
                errors++;
                $display("FAIL illegal_br t=%0t got %b want %b", $time, illegal_br, mon_e.ill);
            end
            if (misalign !== mon_e.mis) begin
                errors++;
                $display("FAIL misalign t=%0t got %b want %b", $time, misalign, mon_e.mis);
            end
            if (mon_e.sq_obs !== mon_e.sq_exp) begin
                errors++;
                $display("FAIL squash t=%0t got %b want %b", $time, mon_e.sq_obs, mon_e.sq_exp);
            end
        end
    end

    // Drive one cycle of stimulus and push the expected result for the next edge.
    task automatic cyc(input logic rst, input logic v, input logic [6:0] opc,
                       input logic [2:0] f3, input logic eq, input logic lt,
                       input logic ltu, input logic [31:0] tgt, input logic fl,
                       input logic e_rv, input logic [31:0] e_pc, input logic e_ill,
                       input logic e_mis, input logic e_sq);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        in_valid = v;
        opcode   = opc;
        funct3   = f3;
        br_eq    = eq;
        br_lt    = lt;
        br_ltu   = ltu;
        target   = tgt;
        flush_in = fl;
        #1;
        if (!rst) exp_pc = 32'd0;
        else if (e_rv) exp_pc = e_pc;
        e.rv     = rst ? e_rv : 1'b0;
        e.pc     = exp_pc;
        e.ill    = rst ? e_ill : 1'b0;
        e.mis    = rst ? e_mis : 1'b0;
        e.sq_exp = e_sq;
        e.sq_obs = squash;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1, 0, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(0, 1, OP_JAL, 3'd0, 0, 0, 0, 32'h0000_0800, 0, 0, 32'd0, 0, 0, 0);
        cyc(0, 1, OP_BR, 3'b010, 0, 0, 0, 32'h0000_0801, 0, 0, 32'd0, 0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        opcode   = OP_ALU;
        #1;
        checks += 3;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        if (redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_redirect_pc got %h want 0", redirect_pc);
        end
        if (squash !== 1'b0) begin
            errors++;
            $display("FAIL reset_squash got %b want 0", squash);
        end
        in_valid = 1'b0;
        exp_pc   = 32'd0;
    endtask

    task automatic test_beq_taken();
        cyc(1, 1, OP_BR, 3'b000, 1, 0, 0, 32'h0000_0100, 0, 1, 32'h100, 0, 0, 0);
        cyc(1, 1, OP_JAL, 3'd0, 0, 0, 0, 32'h0000_0900, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b010, 0, 0, 0, 32'h0000_0904, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b001, 1, 0, 0, 32'h0000_0908, 0, 0, 32'd0, 0, 0, 0);
    endtask

    task automatic test_not_taken();
        cyc(1, 1, OP_BR, 3'b111, 0, 0, 1, 32'h0000_0a00, 0, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b100, 0, 0, 0, 32'h0000_0a04, 0, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b101, 0, 0, 1, 32'h0000_0200, 0, 1, 32'h200, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b110, 0, 1, 0, 32'h0000_0a08, 0, 0, 32'd0, 0, 0, 0);
    endtask

    task automatic test_jalr();
        cyc(1, 1, OP_JALR, 3'd0, 0, 0, 0, 32'h0000_2003, 0, 0, 32'd0, 0, 1, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_JALR, 3'd0, 0, 0, 0, 32'h0000_2001, 0, 1, 32'h2000, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_JAL, 3'd0, 0, 0, 0, 32'h0000_0006, 0, 0, 32'd0, 0, 1, 0);
    endtask

    task automatic test_illegal();
        cyc(1, 1, OP_BR, 3'b011, 1, 1, 1, 32'h0000_0c00, 0, 0, 32'd0, 1, 0, 0);
        cyc(1, 1, OP_BR, 3'b010, 0, 0, 0, 32'h0000_0c00, 0, 0, 32'd0, 1, 0, 0);
        idle(1);
    endtask

    task automatic test_idle_squash();
        cyc(1, 1, OP_JAL, 3'd0, 0, 0, 0, 32'h0000_3000, 0, 1, 32'h3000, 0, 0, 0);
        idle(3);
        cyc(1, 1, OP_BR, 3'b000, 1, 0, 0, 32'h0000_3100, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_JALR, 3'd0, 0, 0, 0, 32'h0000_3103, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    endtask

    task automatic test_flush();
        cyc(1, 1, OP_BR, 3'b001, 0, 0, 0, 32'h0000_0300, 1, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b000, 1, 0, 0, 32'h0000_0400, 0, 1, 32'h400, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 1, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b110, 0, 0, 1, 32'h0000_0500, 0, 1, 32'h500, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
    endtask

    task automatic test_reset_mid_squash();
        cyc(1, 1, OP_JAL, 3'd0, 0, 0, 0, 32'h0000_0600, 0, 1, 32'h600, 0, 0, 0);
        cyc(0, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b100, 0, 1, 0, 32'h0000_0700, 0, 1, 32'h700, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        cyc(0, 0, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b000, 1, 0, 0, 32'h0000_1000, 0, 1, 32'h1000, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b000, 1, 0, 0, 32'h0000_1100, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 1);
        cyc(1, 1, OP_BR, 3'b001, 1, 0, 0, 32'h0000_1200, 0, 0, 32'd0, 0, 0, 0);
        cyc(1, 1, OP_BR, 3'b100, 0, 1, 0, 32'h0000_1300, 0, 1, 32'h1300, 0, 0, 0);
        cyc(1, 1, OP_ALU, 3'd0, 0, 0, 0, 32'd0, 1, 0, 32'd0, 0, 0, 1);
        @(posedge clk);
        #2;
        checks += 2;
        if (stat_branches !== 32'd3) begin
            errors++;
            $display("FAIL stat_branches got %0d want 3", stat_branches);
        end
        if (stat_taken !== 32'd2) begin
            errors++;
            $display("FAIL stat_taken got %0d want 2", stat_taken);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_beq_taken();
        test_not_taken();
        test_jalr();
        test_illegal();
        test_idle_squash();
        test_flush();
        test_reset_mid_squash();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        idle(2);
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above never completes.
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
